seven_seg_scan: RTL and testbench

- Downstream display stage for the binary-to-BCD converter: consumes four BCD digits (thousands, hundreds, tens, ones) and time-multiplexes them onto a 4-digit common-anode seven-segment display.
- Snapshots the digits once per scan frame so the display never tears, decodes each digit to segments, and blanks leading zeros.
- Sits between the BCD converter outputs and the board's anode/cathode pins.

---
 rtl/seven_seg_scan.sv | 104 ++++++++++
 tb/tb_seven_seg_scan.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Scans four snapshotted BCD digits onto a common-anode 4-digit display with leading-zero blanking.
// Latency: anode/segments are registered, one clk after index/snapshot change; no backpressure, free-running.
module seven_seg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter bit LZ_BLANK    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] thousands,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [3:0] anode,
  output logic [6:0] segments,
  output logic       frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    snap_th, snap_hu, snap_te, snap_on;
  logic          primed;

  logic          wrap;
  logic          snap_now;
  logic [3:0]    digit;
  logic          lz;
  logic          lit;
  logic [6:0]    seg_dec;
  logic [3:0]    an_nx;
  logic [6:0]    seg_nx;

  assign wrap     = (cnt == CW'(REFRESH_DIV - 1));
  // Snapshot only at frame boundaries so a frame never mixes old and new digits.
  assign snap_now = !primed || (wrap && (idx == 2'd3));

  always_comb begin
    digit = snap_on;
    lz    = 1'b0;
    case (idx)
      2'd0: begin digit = snap_on; lz = 1'b0; end
      2'd1: begin digit = snap_te; lz = (snap_th == 4'd0) && (snap_hu == 4'd0) && (snap_te == 4'd0); end
      2'd2: begin digit = snap_hu; lz = (snap_th == 4'd0) && (snap_hu == 4'd0); end
      default: begin digit = snap_th; lz = (snap_th == 4'd0); end
    endcase
  end

  always_comb begin
    case (digit)
      4'd0:    seg_dec = 7'b0000001;
      4'd1:    seg_dec = 7'b1001111;
      4'd2:    seg_dec = 7'b0010010;
      4'd3:    seg_dec = 7'b0000110;
      4'd4:    seg_dec = 7'b1001100;
      4'd5:    seg_dec = 7'b0100100;
      4'd6:    seg_dec = 7'b0100000;
      4'd7:    seg_dec = 7'b0001111;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0000100;
      default: seg_dec = 7'b1111110;
    endcase
  end

  always_comb begin
    lit    = en && !(LZ_BLANK && lz);
    an_nx  = 4'b1111;
    seg_nx = 7'b1111111;
    if (lit) begin
      an_nx[idx] = 1'b0;
      seg_nx     = seg_dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      snap_th    <= 4'd0;
      snap_hu    <= 4'd0;
      snap_te    <= 4'd0;
      snap_on    <= 4'd0;
      primed     <= 1'b0;
      frame_done <= 1'b0;
      anode      <= 4'b1111;
      segments   <= 7'b1111111;
    end else begin
      cnt        <= wrap ? '0 : cnt + CW'(1);
      if (wrap) idx <= idx + 2'd1;
      primed     <= 1'b1;
      frame_done <= snap_now;
      if (snap_now) begin
        snap_th <= thousands;
        snap_hu <= hundreds;
        snap_te <= tens;
        snap_on <= ones;
      end
      anode      <= an_nx;
      segments   <= seg_nx;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: a cycle model pushes expected outputs at each clk edge, negedge pops and compares.
module tb_seven_seg_scan;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b1;
  logic [3:0] thousands = 4'd0, hundreds = 4'd0, tens = 4'd0, ones = 4'd0;
  logic [3:0] anode0, anode1;
  logic [6:0] segments0, segments1;
  logic       frame_done0, frame_done1;

  int checks   = 0;
  int failures = 0;

  seven_seg_scan #(.REFRESH_DIV(RD), .LZ_BLANK(1'b1)) u_lz (
    .clk(clk), .rst(rst), .en(en),
    .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones),
    .anode(anode0), .segments(segments0), .frame_done(frame_done0)
  );

  seven_seg_scan #(.REFRESH_DIV(RD), .LZ_BLANK(1'b0)) u_nolz (
    .clk(clk), .rst(rst), .en(en),
    .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones),
    .anode(anode1), .segments(segments1), .frame_done(frame_done1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111110;
    endcase
  endfunction

  typedef struct packed {
    logic [3:0] an0;
    logic [6:0] sg0;
    logic [3:0] an1;
    logic [6:0] sg1;
    logic       fd;
  } exp_t;

  exp_t       exp_q[$];
  int         m_cnt = 0;
  int         m_idx = 0;
  logic [3:0] m_snap [4];   // [0]=ones .. [3]=thousands
  bit         m_primed = 0;

  // Reference model: what the display should show after each clk edge.
  always @(posedge clk or posedge rst) begin
    exp_t e;
    bit   frame;
    bit   blank;
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_primed = 0;
      for (int k = 0; k < 4; k++) m_snap[k] = 4'd0;
      exp_q.delete();
    end else begin
      case (m_idx)
        3:       blank = (m_snap[3] == 0);
        2:       blank = (m_snap[3] == 0) && (m_snap[2] == 0);
        1:       blank = (m_snap[3] == 0) && (m_snap[2] == 0) && (m_snap[1] == 0);
        default: blank = 0;
      endcase
      e.an1 = 4'b1111;
      e.sg1 = 7'b1111111;
      if (en) begin
        e.an1[m_idx] = 1'b0;
        e.sg1 = seg_of(m_snap[m_idx]);
      end
      e.an0 = (en && !blank) ? e.an1 : 4'b1111;
      e.sg0 = (en && !blank) ? e.sg1 : 7'b1111111;
      frame = !m_primed || (m_cnt == RD - 1 && m_idx == 3);
      e.fd  = frame;
      if (frame) begin
        m_snap[0] = ones; m_snap[1] = tens; m_snap[2] = hundreds; m_snap[3] = thousands;
      end
      m_primed = 1;
      if (m_cnt == RD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("anode_lz",    32'(anode0),      32'(e.an0));
      chk("seg_lz",      32'(segments0),   32'(e.sg0));
      chk("anode_nolz",  32'(anode1),      32'(e.an1));
      chk("seg_nolz",    32'(segments1),   32'(e.sg1));
      chk("frame_lz",    32'(frame_done0), 32'(e.fd));
      chk("frame_nolz",  32'(frame_done1), 32'(e.fd));
      chk("anode_onehot", 32'($countones(~anode0) <= 1), 32'd1);
    end
  end

  task automatic set_digits(input logic [3:0] th, input logic [3:0] hu, input logic [3:0] te, input logic [3:0] on);
    thousands = th; hundreds = hu; tens = te; ones = on;
  endtask

  // Bounded wait (at negedges) until the model reaches a given slot/count.
  task automatic wait_slot(input string tag, input int idx, input int cnt);
    bit hit = 0;
    for (int n = 0; n < 64 && !hit; n++) begin
      @(negedge clk);
      hit = (m_idx == idx) && (m_cnt == cnt);
    end
    if (!hit) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_anode", 32'(anode0),      32'hf);
    chk("rst_seg",   32'(segments0),   32'h7f);
    chk("rst_frame", 32'(frame_done0), 32'd0);
    rst = 1'b0;

    repeat (40) @(negedge clk);

    // Inputs change mid-frame in the tens slot; snapshot holds 1234 until next frame.
    wait_slot("wait_tens", 1, 1);
    set_digits(4'd5, 4'd6, 4'd7, 4'd8);
    repeat (40) @(negedge clk);

    set_digits(4'd12, 4'd0, 4'd9, 4'd3);
    repeat (40) @(negedge clk);

    set_digits(4'd0, 4'd0, 4'd0, 4'd7);
    repeat (40) @(negedge clk);

    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (40) @(negedge clk);

    set_digits(4'd0, 4'd3, 4'd0, 4'd15);
    repeat (40) @(negedge clk);

    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (20) @(negedge clk);
    wait_slot("wait_en", 2, 1);
    en = 1'b0;
    repeat (6) @(negedge clk);
    en = 1'b1;
    repeat (40) @(negedge clk);

    // Asynchronous reset between edges in the hundreds slot.
    wait_slot("wait_hund", 2, 1);
    chk("pre_rst_anode", 32'(anode0), 32'b1011);
    #2 rst = 1'b1;
    #1;
    chk("arst_anode",    32'(anode0),      32'hf);
    chk("arst_seg",      32'(segments0),   32'h7f);
    chk("arst_frame",    32'(frame_done0), 32'd0);
    chk("arst_anode_nl", 32'(anode1),      32'hf);
    @(negedge clk);
    set_digits(4'd9, 4'd8, 4'd7, 4'd6);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
